// File: rtl/ram_simple2port_pipe_pkg.sv
// Shared constants and lane helpers for the simple two-port pipelined RAM.
package ram_pkg;

  localparam int RDLAT_MIN = 1;
  localparam int RDLAT_MAX = 4;
  // Widest word / lane count the merge helper handles.
  localparam int RAM_MAXW  = 4096;
  localparam int RAM_MAXL  = 256;

  function automatic int lane_width(input int bdword, input int nlane);
    return bdword / nlane;
  endfunction

  // Lanes whose mask bit is set take new_w; the rest keep old_w.
  function automatic logic [RAM_MAXW-1:0] lane_merge(
    input logic [RAM_MAXW-1:0] old_w,
    input logic [RAM_MAXW-1:0] new_w,
    input logic [RAM_MAXL-1:0] mask,
    input int                  lw,
    input int                  nlane
  );
    logic [RAM_MAXW-1:0] lane_m;
    logic [RAM_MAXW-1:0] bit_m;
    logic [RAM_MAXL-1:0] sh;
    lane_m = {RAM_MAXW{1'b1}} >> (RAM_MAXW - lw);
    bit_m  = '0;
    for (int l = 0; l < nlane; l++) begin
      sh = mask >> l;
      if (sh[0]) bit_m = bit_m | (lane_m << (l * lw));
    end
    return (old_w & ~bit_m) | (new_w & bit_m);
  endfunction

endpackage

// File: rtl/ram_simple2port_pipe_if.sv
// Read/write bus of the simple two-port RAM; master drives requests, slave is the RAM.
interface ram_simple2port_pipe_if #(
  parameter int BDADDR = 12,
  parameter int BDWORD = 2048,
  parameter int NLANE  = 64
);
  logic              rd_en;
  logic [BDADDR-1:0] rd_addr;
  logic [BDWORD-1:0] rd_word;
  logic              rd_valid;
  logic              wr_en;
  logic [NLANE-1:0]  wr_lane_en;
  logic [BDADDR-1:0] wr_addr;
  logic [BDWORD-1:0] wr_word;

  modport master (
    output rd_en, rd_addr, wr_en, wr_lane_en, wr_addr, wr_word,
    input  rd_word, rd_valid
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_lane_en, wr_addr, wr_word,
    output rd_word, rd_valid
  );
endinterface

// File: rtl/ram_simple2port_pipe_rd_pipe.sv
// Read-data delay line (data+valid) with async clear; output is zero when not valid.
module ram_rd_pipe #(
  parameter int DEPTH  = 1,
  parameter int BDWORD = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_i,
  input  logic [BDWORD-1:0] dat_i,
  output logic              vld_o,
  output logic [BDWORD-1:0] dat_o
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign vld_o = vld_i;
      assign dat_o = vld_i ? dat_i : '0;
    end else begin : g_pipe
      logic [DEPTH-1:0]             vld_pipe_q, vld_pipe_d;
      logic [DEPTH-1:0][BDWORD-1:0] dat_pipe_q, dat_pipe_d;

      always_comb begin
        vld_pipe_d    = '0;
        dat_pipe_d    = '0;
        vld_pipe_d[0] = vld_i;
        dat_pipe_d[0] = dat_i;
        for (int i = 1; i < DEPTH; i++) begin
          vld_pipe_d[i] = vld_pipe_q[i-1];
          dat_pipe_d[i] = dat_pipe_q[i-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_pipe_q <= '0;
          dat_pipe_q <= '0;
        end else begin
          vld_pipe_q <= vld_pipe_d;
          dat_pipe_q <= dat_pipe_d;
        end
      end

      assign vld_o = vld_pipe_q[DEPTH-1];
      assign dat_o = vld_pipe_q[DEPTH-1] ? dat_pipe_q[DEPTH-1] : '0;
    end
  endgenerate

endmodule

// File: rtl/ram_simple2port_pipe.sv
// 1R/1W synchronous RAM with per-lane write enables and RDLAT-cycle read pipeline.
// Define RAM_S2P_FWD_EN for write-first same-address forwarding (default read-first).
module ram_simple2port_pipe
  import ram_pkg::*;
#(
  parameter int BDADDR = 12,
  parameter int BDWORD = 2048,
  parameter int NLANE  = 64,
  parameter int RDLAT  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  ram_simple2port_pipe_if.slave  bus
);

  localparam int LW    = lane_width(BDWORD, NLANE);
  localparam int DEPTH = 2 ** BDADDR;

  generate
    if (BDWORD % NLANE != 0) begin : g_err_lane
      $error("ram_simple2port_pipe: BDWORD (%0d) not a multiple of NLANE (%0d)", BDWORD, NLANE);
    end
    if (RDLAT < RDLAT_MIN || RDLAT > RDLAT_MAX) begin : g_err_lat
      $error("ram_simple2port_pipe: RDLAT (%0d) outside %0d..%0d", RDLAT, RDLAT_MIN, RDLAT_MAX);
    end
    if (BDWORD > RAM_MAXW || NLANE > RAM_MAXL) begin : g_err_size
      $error("ram_simple2port_pipe: BDWORD/NLANE exceed lane_merge limits");
    end
  endgenerate

  logic [BDWORD-1:0] mem_q [DEPTH];
  logic [BDWORD-1:0] wr_merged_d;

  always_comb begin
    wr_merged_d = BDWORD'(lane_merge(RAM_MAXW'(mem_q[bus.wr_addr]), RAM_MAXW'(bus.wr_word),
                                     RAM_MAXL'(bus.wr_lane_en), LW, NLANE));
  end

  // Array is deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (bus.wr_en) mem_q[bus.wr_addr] <= wr_merged_d;
  end

  // Stage 1: registered array read.
  logic              rd_vld_q, rd_vld_d;
  logic [BDWORD-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_vld_d  = bus.rd_en;
    rd_data_d = '0;
    if (bus.rd_en) begin
      rd_data_d = mem_q[bus.rd_addr];
`ifdef RAM_S2P_FWD_EN
      if (bus.wr_en && (bus.wr_addr == bus.rd_addr)) rd_data_d = wr_merged_d;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Stages 2..RDLAT.
  logic              pipe_vld;
  logic [BDWORD-1:0] pipe_dat;

  ram_rd_pipe #(
    .DEPTH  (RDLAT - 1),
    .BDWORD (BDWORD)
  ) u_rd_pipe (
    .clk   (clk),
    .rst   (rst),
    .vld_i (rd_vld_q),
    .dat_i (rd_data_q),
    .vld_o (pipe_vld),
    .dat_o (pipe_dat)
  );

  assign bus.rd_valid = pipe_vld;
  assign bus.rd_word  = pipe_dat;

endmodule

// File: tb/tb_ram_simple2port_pipe.sv
// Directed self-checking bench for ram_simple2port_pipe (BDADDR=4, BDWORD=32, NLANE=4).
module tb_ram_simple2port_pipe;
  localparam int BDADDR = 4;
  localparam int BDWORD = 32;
  localparam int NLANE  = 4;
  parameter  int RDLAT  = 2;

`ifdef RAM_S2P_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_simple2port_pipe_if #(.BDADDR(BDADDR), .BDWORD(BDWORD), .NLANE(NLANE)) bus ();

  ram_simple2port_pipe #(
    .BDADDR (BDADDR), .BDWORD (BDWORD), .NLANE (NLANE), .RDLAT (RDLAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, want %08h", tag, obs, exp);
    end
  endtask

  // Watches negedges after the issue edge; only the RDLAT-th may be valid.
  task automatic rsp_chk(input string tag, input logic [31:0] exp);
    for (int k = 1; k <= RDLAT + 1; k++) begin
      @(negedge clk);
      if (k == RDLAT) begin
        chk({tag, ".vld"}, {31'b0, bus.rd_valid}, 32'd1);
        chk({tag, ".dat"}, bus.rd_word, exp);
      end else begin
        chk({tag, ".vld0"}, {31'b0, bus.rd_valid}, 32'd0);
        chk({tag, ".dat0"}, bus.rd_word, 32'd0);
      end
    end
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data,
                    input logic [3:0] mask, input logic en);
    bus.wr_en = en; bus.wr_addr = addr; bus.wr_word = data; bus.wr_lane_en = mask;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic rd_chk(input logic [3:0] addr, input logic [31:0] exp, input string tag);
    bus.rd_en = 1'b1; bus.rd_addr = addr;
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
    rsp_chk(tag, exp);
  endtask

  task automatic rw_chk(input logic [3:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input logic [31:0] exp, input string tag);
    bus.rd_en = 1'b1; bus.rd_addr = addr;
    bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_word = data; bus.wr_lane_en = mask;
    @(posedge clk); #1;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    rsp_chk(tag, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rd_en = 1'b0; bus.rd_addr = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_word = '0; bus.wr_lane_en = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("reset.vld", {31'b0, bus.rd_valid}, 32'd0);
    chk("reset.dat", bus.rd_word, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic write/read and latency.
    wr(4'd3, 32'hDEADBEEF, 4'hF, 1'b1);
    rd_chk(4'd3, 32'hDEADBEEF, "s1");

    // Lane masking, wr_en=0 and empty mask.
    wr(4'd3, 32'h11223344, 4'b0101, 1'b1);
    rd_chk(4'd3, 32'hDE22BE44, "s2_mask");
    wr(4'd3, 32'hFFFFFFFF, 4'hF, 1'b0);
    rd_chk(4'd3, 32'hDE22BE44, "s2_wren0");
    wr(4'd3, 32'hFFFFFFFF, 4'h0, 1'b1);
    rd_chk(4'd3, 32'hDE22BE44, "s2_mask0");

    // Same-cycle read/write collision.
    wr(4'd5, 32'hAAAAAAAA, 4'hF, 1'b1);
    rw_chk(4'd5, 32'h55555555, 4'hF, FWD ? 32'h55555555 : 32'hAAAAAAAA, "s3_full");
    rd_chk(4'd5, 32'h55555555, "s3_full_after");
    wr(4'd5, 32'hAAAAAAAA, 4'hF, 1'b1);
    rw_chk(4'd5, 32'h55555555, 4'b0011, FWD ? 32'hAAAA5555 : 32'hAAAAAAAA, "s3_part");
    rd_chk(4'd5, 32'hAAAA5555, "s3_part_after");

    // Back-to-back streaming reads.
    for (int a = 0; a < 16; a++) wr(4'(a), 32'(a) * 32'h01010101, 4'hF, 1'b1);
    for (int c = 0; c < 16 + RDLAT + 1; c++) begin
      int j;
      bus.rd_en = (c < 16); bus.rd_addr = 4'(c);
      @(posedge clk);
      @(negedge clk);
      j = c - RDLAT + 1;
      if (j >= 0 && j < 16) begin
        chk("s4.vld", {31'b0, bus.rd_valid}, 32'd1);
        chk("s4.dat", bus.rd_word, 32'(j) * 32'h01010101);
      end else begin
        chk("s4.idle", {31'b0, bus.rd_valid}, 32'd0);
      end
    end
    bus.rd_en = 1'b0;

    // Async reset with reads in flight; memory survives.
    wr(4'd3, 32'hDE22BE44, 4'hF, 1'b1);
    bus.rd_en = 1'b1; bus.rd_addr = 4'd3;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("s5.pre", {31'b0, bus.rd_valid}, (RDLAT <= 2) ? 32'd1 : 32'd0);
    rst = 1'b1;
    #1;
    chk("s5.rst_vld", {31'b0, bus.rd_valid}, 32'd0);
    chk("s5.rst_dat", bus.rd_word, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0; bus.rd_en = 1'b0;
    for (int k = 0; k < RDLAT + 2; k++) begin
      @(negedge clk);
      chk("s5.quiet", {31'b0, bus.rd_valid}, 32'd0);
    end
    rd_chk(4'd3, 32'hDE22BE44, "s5_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
